// File: rtl/gpu_pixel_writer.sv
// Sprite pipeline final stage: clips and colour-keys one pixel per handshake and
// writes survivors to the framebuffer as a single AXI-lite halfword write.
module gpu_pixel_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_valid,
  output logic        re_ready,
  input  logic [15:0] re_colour,
  input  logic [15:0] re_screen_x,
  input  logic [15:0] re_screen_y,
  input  logic [31:0] fb_base,
  input  logic [15:0] fb_width,
  input  logic [15:0] fb_height,
  input  logic        trans_en,
  input  logic [15:0] trans_colour,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        err,
  output logic [31:0] written_cnt,
  output logic [31:0] dropped_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t      state_q;
  logic [31:0] pix_addr_c;
  logic        drop_c;
  logic        aw_done_c;
  logic        w_done_c;

  // Byte address of the halfword pixel; wraps modulo 2^32.
  assign pix_addr_c = fb_base + ((32'(re_screen_y) * 32'(fb_width) + 32'(re_screen_x)) << 1);

  assign drop_c = (re_screen_x >= fb_width) || (re_screen_y >= fb_height) ||
                  (trans_en && (re_colour == trans_colour));

  // A channel is done once its valid is low or it handshakes this cycle.
  assign aw_done_c = !axi_awvalid || axi_awready;
  assign w_done_c  = !axi_wvalid  || axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      re_ready    <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_awaddr  <= 32'd0;
      axi_wdata   <= 32'd0;
      axi_wstrb   <= 4'd0;
      err         <= 1'b0;
      written_cnt <= 32'd0;
      dropped_cnt <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          re_ready <= 1'b1;
          if (re_valid && re_ready) begin
            if (drop_c) begin
              dropped_cnt <= dropped_cnt + 32'd1;
            end else begin
              axi_awaddr  <= {pix_addr_c[31:2], 2'b00};
              axi_wdata   <= {re_colour, re_colour};
              axi_wstrb   <= pix_addr_c[1] ? 4'b1100 : 4'b0011;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              re_ready    <= 1'b0;
              state_q     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            axi_bready <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (axi_bvalid && axi_bready) begin
            axi_bready  <= 1'b0;
            written_cnt <= written_cnt + 32'd1;
            if (axi_bresp != 2'b00) err <= 1'b1;
            re_ready    <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer: directed vector table, hand-written
// backpressure/reset sequences, and randomized pixels against an arithmetic model.
module tb_gpu_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_valid;
  logic        re_ready;
  logic [15:0] re_colour, re_screen_x, re_screen_y;
  logic [31:0] fb_base;
  logic [15:0] fb_width, fb_height;
  logic        trans_en;
  logic [15:0] trans_colour;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic        err;
  logic [31:0] written_cnt, dropped_cnt;

  int total = 0;
  int bad   = 0;
  int exp_written = 0;
  int exp_dropped = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  gpu_pixel_writer dut (
    .clk(clk), .rst(rst),
    .re_valid(re_valid), .re_ready(re_ready), .re_colour(re_colour),
    .re_screen_x(re_screen_x), .re_screen_y(re_screen_y),
    .fb_base(fb_base), .fb_width(fb_width), .fb_height(fb_height),
    .trans_en(trans_en), .trans_colour(trans_colour),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_bresp(axi_bresp), .err(err), .written_cnt(written_cnt), .dropped_cnt(dropped_cnt)
  );

  typedef struct {
    logic [15:0] x, y, c;
    bit          te;
    bit          drop;
    logic [31:0] addr;
    logic [3:0]  strb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic from the clip/key/address rules.
  function automatic bit model_drop(input logic [15:0] x, y, c);
    return (int'(x) >= int'(fb_width)) || (int'(y) >= int'(fb_height)) ||
           (trans_en && c == trans_colour);
  endfunction

  function automatic longint unsigned model_byte(input logic [15:0] x, y);
    longint unsigned a;
    a = (longint'(fb_base) + 2 * (longint'(y) * longint'(fb_width) + longint'(x))) % 64'h1_0000_0000;
    return a;
  endfunction

  function automatic logic [31:0] model_addr(input logic [15:0] x, y);
    return 32'(model_byte(x, y) - (model_byte(x, y) % 4));
  endfunction

  function automatic logic [3:0] model_strb(input logic [15:0] x, y);
    return (model_byte(x, y) % 4 >= 2) ? 4'b1100 : 4'b0011;
  endfunction

  // Offers one pixel and plays the AXI slave with the given delays.
  task automatic do_pixel(input logic [15:0] x, y, c, input bit exp_drop,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input int aw_dly, w_dly, b_dly, input logic [1:0] resp,
                          output int lat);
    int cyc;
    bit aw_done, w_done, awh, wh, bh;
    logic [31:0] sv_base;
    logic [15:0] sv_w;
    lat = 0;
    cyc = 0;
    while (!re_ready && cyc < 20) begin tick(); cyc++; end
    check("ready_before_accept", re_ready, 1);
    re_valid = 1'b1; re_screen_x = x; re_screen_y = y; re_colour = c;
    tick();
    re_valid = 1'b0;
    lat = 1;
    if (exp_drop) begin
      exp_dropped++;
      check("drop_awvalid", axi_awvalid, 0);
      check("drop_wvalid", axi_wvalid, 0);
      check("drop_ready", re_ready, 1);
      check("dropped_cnt", dropped_cnt, exp_dropped);
      return;
    end
    check("awvalid_n1", axi_awvalid, 1);
    check("wvalid_n1", axi_wvalid, 1);
    check("ready_low", re_ready, 0);
    check("awaddr", axi_awaddr, exp_addr);
    check("wdata", axi_wdata, {c, c});
    check("wstrb", axi_wstrb, exp_strb);
    // Disturb the quasi-static inputs; the transaction in flight must not change.
    sv_base = fb_base; sv_w = fb_width;
    fb_base = ~fb_base; fb_width = fb_width + 16'd7;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      axi_awready = (cyc >= aw_dly);
      axi_wready  = (cyc >= w_dly);
      awh = axi_awvalid && axi_awready;
      wh  = axi_wvalid && axi_wready;
      if (axi_awvalid) check("awaddr_stable", axi_awaddr, exp_addr);
      if (axi_wvalid) check("wdata_stable", axi_wdata, {c, c});
      tick(); cyc++; lat++;
      if (awh) aw_done = 1;
      if (wh) w_done = 1;
      check("awvalid_track", axi_awvalid, !aw_done);
      check("wvalid_track", axi_wvalid, !w_done);
      check("bready_track", axi_bready, aw_done && w_done);
    end
    axi_awready = 1'b0; axi_wready = 1'b0;
    if (!(aw_done && w_done)) check("write_timeout", 0, 1);
    cyc = 0; bh = 0;
    while (!bh && cyc < 50) begin
      axi_bvalid = (cyc >= b_dly);
      axi_bresp  = resp;
      check("bready_held", axi_bready, 1);
      check("ready_low_resp", re_ready, 0);
      bh = axi_bvalid && axi_bready;
      tick(); cyc++; lat++;
    end
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    if (!bh) check("resp_timeout", 0, 1);
    exp_written++;
    if (resp != 2'b00) exp_err = 1'b1;
    fb_base = sv_base; fb_width = sv_w;
    check("bready_low", axi_bready, 0);
    check("ready_back", re_ready, 1);
    check("written_cnt", written_cnt, exp_written);
    check("err", err, exp_err);
  endtask

  vec_t vecs[9];
  int   lat;

  initial begin
    rst = 1'b1; re_valid = 1'b0; re_colour = '0; re_screen_x = '0; re_screen_y = '0;
    fb_base = 32'h1000_0000; fb_width = 16'd320; fb_height = 16'd240;
    trans_en = 1'b0; trans_colour = 16'hF81F;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;

    vecs[0] = '{x:3,   y:2,   c:16'hABCD, te:0, drop:0, addr:32'h1000_0504, strb:4'b1100};
    vecs[1] = '{x:2,   y:2,   c:16'hABCD, te:0, drop:0, addr:32'h1000_0504, strb:4'b0011};
    vecs[2] = '{x:320, y:0,   c:16'h1234, te:0, drop:1, addr:32'h0,         strb:4'b0000};
    vecs[3] = '{x:0,   y:240, c:16'h1234, te:0, drop:1, addr:32'h0,         strb:4'b0000};
    vecs[4] = '{x:319, y:239, c:16'h1234, te:0, drop:0, addr:32'h1002_57FC, strb:4'b1100};
    vecs[5] = '{x:5,   y:0,   c:16'hF81F, te:1, drop:1, addr:32'h0,         strb:4'b0000};
    vecs[6] = '{x:5,   y:0,   c:16'hF81E, te:1, drop:0, addr:32'h1000_0008, strb:4'b1100};
    vecs[7] = '{x:5,   y:0,   c:16'hF81F, te:0, drop:0, addr:32'h1000_0008, strb:4'b1100};
    vecs[8] = '{x:5,   y:0,   c:16'hF81E, te:0, drop:0, addr:32'h1000_0008, strb:4'b1100};

    tick(); tick();
    check("rst_ready", re_ready, 0);
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wvalid", axi_wvalid, 0);
    check("rst_bready", axi_bready, 0);
    check("rst_awaddr", axi_awaddr, 0);
    check("rst_wdata", axi_wdata, 0);
    check("rst_wstrb", axi_wstrb, 0);
    check("rst_counts", written_cnt | dropped_cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", re_ready, 1);

    for (int i = 0; i < 9; i++) begin
      trans_en = vecs[i].te;
      do_pixel(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].drop, vecs[i].addr, vecs[i].strb,
               0, 0, 0, 2'b00, lat);
      if (i == 0) check("latency_3", lat, 3);
    end

    // Backpressure: W ready two cycles ahead of AW, slow SLVERR response.
    do_pixel(16'd10, 16'd1, 16'h0F0F, 0, 32'h1000_0294, 4'b0011, 2, 0, 5, 2'b10, lat);
    check("err_set", err, 1);
    do_pixel(16'd11, 16'd1, 16'h0F0F, 0, 32'h1000_0294, 4'b1100, 0, 1, 0, 2'b00, lat);
    check("err_sticky", err, 1);

    // Reset while stuck in WRITE.
    re_valid = 1'b1; re_screen_x = 16'd1; re_screen_y = 16'd1; re_colour = 16'h5555;
    tick();
    re_valid = 1'b0;
    check("mid_awvalid", axi_awvalid, 1);
    tick();
    rst = 1'b1;
    tick();
    check("mrst_awvalid", axi_awvalid, 0);
    check("mrst_wvalid", axi_wvalid, 0);
    check("mrst_ready", re_ready, 0);
    check("mrst_written", written_cnt, 0);
    check("mrst_dropped", dropped_cnt, 0);
    check("mrst_err", err, 0);
    rst = 1'b0;
    exp_written = 0; exp_dropped = 0; exp_err = 1'b0;
    tick();
    check("mrst_ready_back", re_ready, 1);
    do_pixel(16'd1, 16'd1, 16'h5555, 0, 32'h1000_0280, 4'b1100, 0, 0, 0, 2'b00, lat);

    // Randomized pixels against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] x, y, c;
      if (i % 25 == 0) begin
        fb_base   = $urandom() & 32'hFFFF_FFFE;
        fb_width  = 16'($urandom_range(1, 400));
        fb_height = 16'($urandom_range(1, 300));
        trans_colour = 16'($urandom());
      end
      trans_en = 1'($urandom_range(0, 1));
      x = 16'($urandom_range(0, 420));
      y = 16'($urandom_range(0, 320));
      c = ($urandom_range(0, 3) == 0) ? trans_colour : 16'($urandom());
      do_pixel(x, y, c, model_drop(x, y, c), model_addr(x, y), model_strb(x, y),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b00, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
